// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 keyboard receiver with clock deglitch, odd-parity framing and timeout
module ps2_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 20000
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic [7:0] DATA,
   output logic       VALID,
   output logic       ERROR
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [4:0]  LP_FILT_LAST = 5'(FILTER_LEN - 1);
   localparam logic [15:0] LP_TIMEOUT   = 16'(TIMEOUT);

   logic        r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic        r_fclk, r_fclk_d, r_fall;
   logic [4:0]  r_fcnt;
   logic [15:0] r_tcnt;
   state_t      r_state, w_state_nxt;
   logic [2:0]  r_bit, w_bit_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic        r_par, w_par_nxt;
   logic [7:0]  r_data, w_data_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_error, w_error_nxt;
   logic        w_timeout;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= PS2_CLK;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= PS2_DATA;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // r_fcnt counts consecutive samples that disagree with the filtered level
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_fclk   <= 1'b1;
         r_fclk_d <= 1'b1;
         r_fall   <= 1'b0;
         r_fcnt   <= 5'd0;
      end else begin
         r_fclk_d <= r_fclk;
         r_fall   <= r_fclk_d & ~r_fclk;
         if (r_clk_s2 == r_fclk) begin
            r_fcnt <= 5'd0;
         end else if (r_fcnt == LP_FILT_LAST) begin
            r_fclk <= r_clk_s2;
            r_fcnt <= 5'd0;
         end else begin
            r_fcnt <= r_fcnt + 5'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_tcnt <= 16'd0;
      end else if (r_fall || (r_state == S_IDLE)) begin
         r_tcnt <= 16'd0;
      end else if (r_tcnt != 16'hFFFF) begin
         r_tcnt <= r_tcnt + 16'd1;
      end
   end

   assign w_timeout = (r_state != S_IDLE) && (r_tcnt == LP_TIMEOUT);

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= S_IDLE;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_par   <= 1'b0;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_error <= w_error_nxt;
      end
   end

   // Timeout outranks a coincident fall so an abandoned frame never shifts another bit
   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_error_nxt = 1'b0;
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
         w_error_nxt = 1'b1;
      end else if (r_fall) begin
         case (r_state)
            S_IDLE: begin
               if (!r_dat_s2) begin
                  w_state_nxt = S_DATA;
                  w_bit_nxt   = 3'd0;
               end
            end
            S_DATA: begin
               w_shift_nxt = {r_dat_s2, r_shift[7:1]};
               w_bit_nxt   = r_bit + 3'd1;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_PARITY;
               end
            end
            S_PARITY: begin
               w_par_nxt   = r_dat_s2;
               w_state_nxt = S_STOP;
            end
            S_STOP: begin
               w_state_nxt = S_IDLE;
               if (r_dat_s2 && (^{r_shift, r_par})) begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_error_nxt = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign DATA  = r_data;
   assign VALID = r_valid;
   assign ERROR = r_error;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed frame bench for ps2_rx
`timescale 1ns/1ps
module tb_ps2_rx;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 200;
   localparam int HB         = 40;

   logic       CLK      = 1'b0;
   logic       nRESET   = 1'b0;
   logic       PS2_CLK  = 1'b1;
   logic       PS2_DATA = 1'b1;
   logic [7:0] DATA;
   logic       VALID;
   logic       ERROR;

   int         checks    = 0;
   int         failures  = 0;
   int         valid_cnt = 0;
   int         error_cnt = 0;
   int         both_cnt  = 0;
   logic [7:0] valid_data = 8'h00;
   int         v_lat;
   int         v0, e0;

   ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
      .CLK      (CLK),
      .nRESET   (nRESET),
      .PS2_CLK  (PS2_CLK),
      .PS2_DATA (PS2_DATA),
      .DATA     (DATA),
      .VALID    (VALID),
      .ERROR    (ERROR)
   );

   always #500 CLK = ~CLK;

   always @(negedge CLK) begin
      if (VALID) begin
         valid_cnt++;
         valid_data = DATA;
      end
      if (ERROR) error_cnt++;
      if (VALID && ERROR) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] mkf(input logic [7:0] d, input logic par, input logic stp);
      return {stp, par, d, 1'b0};
   endfunction

   task automatic ps2_bit(input logic b, input logic glitch);
      @(negedge CLK);
      PS2_DATA = b;
      repeat (HB/2) @(negedge CLK);
      PS2_CLK = 1'b0;
      for (int j = 1; j <= HB; j++) begin
         @(posedge CLK);
         #1;
         if (VALID && (v_lat == 0)) v_lat = j;
      end
      @(negedge CLK);
      PS2_CLK = 1'b1;
      repeat (HB/2) @(negedge CLK);
      if (glitch) begin
         PS2_CLK = 1'b0;
         repeat (FILTER_LEN-1) @(negedge CLK);
         PS2_CLK = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [10:0] f, input int nbits, input logic glitch);
      v_lat = 0;
      for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
      PS2_DATA = 1'b1;
      repeat (HB) @(negedge CLK);
   endtask

   task automatic glitch_idle();
      @(negedge CLK);
      PS2_DATA = 1'b0;
      PS2_CLK  = 1'b0;
      repeat (FILTER_LEN-1) @(negedge CLK);
      PS2_CLK  = 1'b1;
      repeat (HB) @(negedge CLK);
      PS2_DATA = 1'b1;
      repeat (HB) @(negedge CLK);
   endtask

   initial begin
      repeat (5) @(negedge CLK);
      check("rst_data",  32'(DATA),  32'h00);
      check("rst_valid", 32'(VALID), 32'h0);
      check("rst_error", 32'(ERROR), 32'h0);
      nRESET = 1'b1;
      repeat (20) @(negedge CLK);

      v0 = valid_cnt; e0 = error_cnt;
      send_frame(mkf(8'h1C, 1'b0, 1'b1), 11, 1'b0);
      check("1c_valid", 32'(valid_cnt - v0), 32'd1);
      check("1c_error", 32'(error_cnt - e0), 32'd0);
      check("1c_data",  32'(DATA),           32'h1C);
      check("1c_lat",   32'(v_lat),          32'(FILTER_LEN + 4));

      v0 = valid_cnt; e0 = error_cnt;
      send_frame(mkf(8'hF0, 1'b1, 1'b1), 11, 1'b0);
      check("f0_valid", 32'(valid_cnt - v0), 32'd1);
      check("f0_pulse", 32'(valid_data),     32'hF0);
      check("f0_lat",   32'(v_lat),          32'(FILTER_LEN + 4));
      send_frame(mkf(8'h1C, 1'b0, 1'b1), 11, 1'b0);
      check("seq_valid", 32'(valid_cnt - v0), 32'd2);
      check("seq_data",  32'(valid_data),     32'h1C);
      check("seq_lat",   32'(v_lat),          32'(FILTER_LEN + 4));
      check("seq_error", 32'(error_cnt - e0), 32'd0);

      v0 = valid_cnt; e0 = error_cnt;
      send_frame(mkf(8'h5A, 1'b0, 1'b1), 11, 1'b0);
      check("par_error", 32'(error_cnt - e0), 32'd1);
      check("par_valid", 32'(valid_cnt - v0), 32'd0);
      check("par_data",  32'(DATA),           32'h1C);

      v0 = valid_cnt; e0 = error_cnt;
      send_frame(mkf(8'h1C, 1'b0, 1'b0), 11, 1'b0);
      check("stop_error", 32'(error_cnt - e0), 32'd1);
      check("stop_valid", 32'(valid_cnt - v0), 32'd0);
      check("stop_data",  32'(DATA),           32'h1C);

      v0 = valid_cnt; e0 = error_cnt;
      send_frame(mkf(8'h5A, 1'b1, 1'b1), 5, 1'b0);
      repeat (TIMEOUT + 100) @(negedge CLK);
      check("to_error", 32'(error_cnt - e0), 32'd1);
      check("to_valid", 32'(valid_cnt - v0), 32'd0);
      send_frame(mkf(8'h5A, 1'b1, 1'b1), 11, 1'b0);
      check("to_next_valid", 32'(valid_cnt - v0), 32'd1);
      check("to_next_error", 32'(error_cnt - e0), 32'd1);
      check("to_next_data",  32'(DATA),           32'h5A);

      v0 = valid_cnt; e0 = error_cnt;
      glitch_idle();
      send_frame(mkf(8'h1C, 1'b0, 1'b1), 11, 1'b1);
      glitch_idle();
      check("gl_valid", 32'(valid_cnt - v0), 32'd1);
      check("gl_error", 32'(error_cnt - e0), 32'd0);
      check("gl_data",  32'(DATA),           32'h1C);

      v0 = valid_cnt; e0 = error_cnt;
      send_frame(mkf(8'h29, 1'b0, 1'b1), 6, 1'b0);
      @(negedge CLK);
      nRESET = 1'b0;
      repeat (3) @(negedge CLK);
      check("mr_data",  32'(DATA),  32'h00);
      check("mr_valid", 32'(VALID), 32'h0);
      check("mr_error", 32'(ERROR), 32'h0);
      nRESET = 1'b1;
      repeat (TIMEOUT + 50) @(negedge CLK);
      check("mr_quiet_v", 32'(valid_cnt - v0), 32'd0);
      check("mr_quiet_e", 32'(error_cnt - e0), 32'd0);
      send_frame(mkf(8'h29, 1'b0, 1'b1), 11, 1'b0);
      check("mr_29_valid", 32'(valid_cnt - v0), 32'd1);
      check("mr_29_error", 32'(error_cnt - e0), 32'd0);
      check("mr_29_data",  32'(DATA),           32'h29);

      check("never_both", 32'(both_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
